// File: rtl/ir_pkg.sv
// ir_pkg
// Shared definitions for the IR link: letter width, default queue depth,
// transmitter acknowledge window and the letter scheduler state encoding.
// Used by both the transmitter-side scheduler and the receiver side.
package ir_pkg;

   localparam int IR_LETTER_W      = 5;   // 0..25 = A..Z
   localparam int IR_DEPTH         = 16;
   localparam int IR_BUSY_WAIT_MAX = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } sched_state_t;

endpackage

// File: rtl/letter_ring_buffer.sv
// letter_ring_buffer
// Circular letter queue with separate occupancy counter.
// Ports:
//   clk_in, rst_in      clock, async active-low reset
//   flush               synchronous clear of pointers and count
//   push, wr_data       enqueue request and letter
//   pop                 dequeue request (caller never pops when empty)
//   rd_data             letter at the read pointer (valid when !empty)
//   count, empty, full  occupancy status, all from the registered count
//   dropped             push refused this cycle (full with no pop)
module letter_ring_buffer #(
   parameter int DEPTH    = 16,
   parameter int LETTER_W = 5
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush,
   input  logic                       push,
   input  logic [LETTER_W-1:0]        wr_data,
   input  logic                       pop,
   output logic [LETTER_W-1:0]        rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       dropped
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [LETTER_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic                push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   // A simultaneous pop frees the slot, so a push into a full queue is
   // still accepted when a pop happens in the same cycle.
   assign push_ok = push && (!full || pop);
   assign dropped = push && full && !pop;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk_in) begin
      if (!flush && push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ir_letter_scheduler.sv
// ir_letter_scheduler
// Queues Enigma letters and releases them one at a time to the IR
// transmitter, pacing on the transmitter busy flag.
// Ports:
//   clk_in, rst_in               100 MHz clock, async active-low reset
//   letter_valid_in, letter_in   encoder valid level and letter; push on rising edge
//   flush_in                     synchronous clear of queue, FSM and sticky flags
//   tx_busy_in                   transmitter busy
//   tx_valid_out, tx_data_out    one-cycle launch strobe and held letter
//   count_out, empty_out, full_out  queue occupancy
//   overflow_out                 sticky: a push was dropped while full
//   no_ack_out                   sticky: busy never rose after a launch
//
// state     | meaning
// IDLE      | waiting for a queued letter and an idle transmitter
// LAUNCH    | strobe is high this cycle; arm the acknowledge timer
// WAIT_BUSY | waiting for busy to rise; timeout sets no_ack_out
// WAIT_DONE | transmitter busy; wait for it to drop
module ir_letter_scheduler
   import ir_pkg::*;
#(
   parameter int DEPTH         = IR_DEPTH,
   parameter int LETTER_W      = IR_LETTER_W,
   parameter int BUSY_WAIT_MAX = IR_BUSY_WAIT_MAX
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       letter_valid_in,
   input  logic [LETTER_W-1:0]        letter_in,
   input  logic                       flush_in,
   input  logic                       tx_busy_in,
   output logic                       tx_valid_out,
   output logic [LETTER_W-1:0]        tx_data_out,
   output logic [$clog2(DEPTH+1)-1:0] count_out,
   output logic                       empty_out,
   output logic                       full_out,
   output logic                       overflow_out,
   output logic                       no_ack_out
);

   localparam int TMR_W = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;

   sched_state_t        state;
   logic [TMR_W-1:0]    timer;
   logic                prev_valid;
   logic                push;
   logic                pop;
   logic                dropped;
   logic [LETTER_W-1:0] rd_data;

   // prev_valid resets low, so a valid level already high out of reset
   // is taken as a push.
   assign push = letter_valid_in && !prev_valid && !flush_in;
   assign pop  = (state == IDLE) && !empty_out && !tx_busy_in && !flush_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) prev_valid <= 1'b0;
      else         prev_valid <= letter_valid_in;
   end

   letter_ring_buffer #(
      .DEPTH    (DEPTH),
      .LETTER_W (LETTER_W)
   ) u_ring (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .flush   (flush_in),
      .push    (push),
      .wr_data (letter_in),
      .pop     (pop),
      .rd_data (rd_data),
      .count   (count_out),
      .empty   (empty_out),
      .full    (full_out),
      .dropped (dropped)
   );

   // The acknowledge timer counts down from BUSY_WAIT_MAX-1; reaching
   // zero without busy is the timeout, giving BUSY_WAIT_MAX cycles in
   // WAIT_BUSY.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         timer        <= '0;
         tx_valid_out <= 1'b0;
         tx_data_out  <= '0;
         overflow_out <= 1'b0;
         no_ack_out   <= 1'b0;
      end else if (flush_in) begin
         state        <= IDLE;
         timer        <= '0;
         tx_valid_out <= 1'b0;
         overflow_out <= 1'b0;
         no_ack_out   <= 1'b0;
      end else begin
         if (dropped) overflow_out <= 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data_out  <= rd_data;
                  tx_valid_out <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               tx_valid_out <= 1'b0;
               timer        <= TMR_W'(BUSY_WAIT_MAX - 1);
               state        <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy_in) begin
                  state <= WAIT_DONE;
               end else if (timer == '0) begin
                  no_ack_out <= 1'b1;
                  state      <= IDLE;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy_in) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_letter_scheduler.sv
// tb_ir_letter_scheduler
// Directed bench for ir_letter_scheduler (DEPTH=16, LETTER_W=5,
// BUSY_WAIT_MAX=8). Inputs change 1 time unit after the rising edge,
// outputs are checked at the same point.
module tb_ir_letter_scheduler;

   logic       clk_in;
   logic       rst_in;
   logic       letter_valid_in;
   logic [4:0] letter_in;
   logic       flush_in;
   logic       tx_busy_in;
   logic       tx_valid_out;
   logic [4:0] tx_data_out;
   logic [4:0] count_out;
   logic       empty_out;
   logic       full_out;
   logic       overflow_out;
   logic       no_ack_out;

   int         n_vec = 0;
   int         n_err = 0;
   logic [4:0] got[$];
   int         long_strobe = 0;

   ir_letter_scheduler dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .letter_valid_in (letter_valid_in),
      .letter_in       (letter_in),
      .flush_in        (flush_in),
      .tx_busy_in      (tx_busy_in),
      .tx_valid_out    (tx_valid_out),
      .tx_data_out     (tx_data_out),
      .count_out       (count_out),
      .empty_out       (empty_out),
      .full_out        (full_out),
      .overflow_out    (overflow_out),
      .no_ack_out      (no_ack_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_letter(input logic [4:0] l);
      letter_in       = l;
      letter_valid_in = 1'b1;
      tick();
      letter_valid_in = 1'b0;
      tick();
   endtask

   // Transmitter model: every strobe seen makes busy high for 10 cycles.
   task automatic run_tx(input int ncyc);
      int   bcnt = 0;
      logic prev = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         if (tx_valid_out) begin
            got.push_back(tx_data_out);
            bcnt = 10;
            if (prev) long_strobe++;
         end
         prev       = tx_valid_out;
         tx_busy_in = (bcnt > 0);
         if (bcnt > 0) bcnt--;
         tick();
      end
      tx_busy_in = 1'b0;
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_tx_valid"}, tx_valid_out, 0);
      chk({pfx, "_tx_data"},  tx_data_out,  0);
      chk({pfx, "_count"},    count_out,    0);
      chk({pfx, "_empty"},    empty_out,    1);
      chk({pfx, "_full"},     full_out,     0);
      chk({pfx, "_overflow"}, overflow_out, 0);
      chk({pfx, "_no_ack"},   no_ack_out,   0);
   endtask

   initial begin
      int n;
      logic [4:0] exp_seq[$];

      rst_in          = 1'b0;
      letter_valid_in = 1'b0;
      letter_in       = '0;
      flush_in        = 1'b0;
      tx_busy_in      = 1'b0;

      // Reset state
      #2;
      chk_reset_values("rst");
      tick();
      tick();
      rst_in = 1'b1;
      tick();

      // Three letters queued behind a busy transmitter, then drained
      tx_busy_in = 1'b1;
      push_letter(5'd3);
      push_letter(5'd7);
      push_letter(5'd25);
      chk("t1_count_queued", count_out, 3);
      got.delete();
      long_strobe = 0;
      run_tx(60);
      chk("t1_n_strobes", got.size(), 3);
      exp_seq = '{5'd3, 5'd7, 5'd25};
      for (int i = 0; i < 3 && i < got.size(); i++)
         chk($sformatf("t1_letter%0d", i), got[i], exp_seq[i]);
      chk("t1_single_cycle", long_strobe, 0);
      chk("t1_count_drained", count_out, 0);
      chk("t1_no_ack", no_ack_out, 0);

      // Valid level held for 20 cycles: one push only
      tx_busy_in      = 1'b1;
      letter_in       = 5'd12;
      letter_valid_in = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      letter_valid_in = 1'b0;
      tick();
      chk("t2_count_hold", count_out, 1);

      // Fill to 16 (12 plus 1..15), then 16 is dropped
      for (int i = 1; i <= 15; i++) push_letter(5'(i));
      chk("t3_count_full", count_out, 16);
      chk("t3_full", full_out, 1);
      chk("t3_overflow_before", overflow_out, 0);
      push_letter(5'd16);
      chk("t3_count_after_drop", count_out, 16);
      chk("t3_overflow", overflow_out, 1);

      // Full queue: release busy and push 20 in the same cycle
      tx_busy_in      = 1'b0;
      letter_in       = 5'd20;
      letter_valid_in = 1'b1;
      tick();
      letter_valid_in = 1'b0;
      chk("t4_count_same", count_out, 16);
      chk("t4_overflow_kept", overflow_out, 1);
      chk("t4_strobe", tx_valid_out, 1);
      chk("t4_data", tx_data_out, 12);
      got.delete();
      long_strobe = 0;
      run_tx(280);
      exp_seq.delete();
      exp_seq.push_back(5'd12);
      for (int i = 1; i <= 15; i++) exp_seq.push_back(5'(i));
      exp_seq.push_back(5'd20);
      chk("t4_n_strobes", got.size(), 17);
      for (int i = 0; i < 17 && i < got.size(); i++)
         chk($sformatf("t4_letter%0d", i), got[i], exp_seq[i]);
      chk("t4_single_cycle", long_strobe, 0);
      chk("t4_empty", empty_out, 1);

      // Busy never rises: timeout, then the next letter still goes out
      tx_busy_in      = 1'b0;
      letter_in       = 5'd5;
      letter_valid_in = 1'b1;
      tick();
      chk("t5_count_push", count_out, 1);
      letter_valid_in = 1'b0;
      tick();
      chk("t5_latency_strobe", tx_valid_out, 1);
      chk("t5_latency_data", tx_data_out, 5);
      tick();
      chk("t5_strobe_drop", tx_valid_out, 0);
      n = 1;
      while (!no_ack_out && n < 20) begin
         tick();
         n++;
      end
      chk("t5_no_ack_delay", n, 9);
      chk("t5_no_ack", no_ack_out, 1);
      letter_in       = 5'd22;
      letter_valid_in = 1'b1;
      tick();
      letter_valid_in = 1'b0;
      tick();
      chk("t5_next_strobe", tx_valid_out, 1);
      chk("t5_next_data", tx_data_out, 22);

      // Async reset in WAIT_DONE with five letters queued
      tx_busy_in = 1'b1;
      for (int i = 1; i <= 5; i++) push_letter(5'(i));
      chk("t6_count_queued", count_out, 5);
      #2;
      rst_in = 1'b0;
      #1;
      chk_reset_values("t6_async");
      tick();
      rst_in     = 1'b1;
      tx_busy_in = 1'b0;
      tick();

      // Flush at a push edge clears queue and both sticky flags
      push_letter(5'd2);
      chk("t7_strobe_data", tx_data_out, 2);
      n = 0;
      while (!no_ack_out && n < 20) begin
         tick();
         n++;
      end
      chk("t7_no_ack_set", no_ack_out, 1);
      tx_busy_in = 1'b1;
      for (int i = 0; i <= 16; i++) push_letter(5'(i));
      chk("t7_full", full_out, 1);
      chk("t7_overflow_set", overflow_out, 1);
      flush_in        = 1'b1;
      letter_in       = 5'd4;
      letter_valid_in = 1'b1;
      tick();
      flush_in        = 1'b0;
      letter_valid_in = 1'b0;
      chk("t7_flush_count", count_out, 0);
      chk("t7_flush_empty", empty_out, 1);
      chk("t7_flush_overflow", overflow_out, 0);
      chk("t7_flush_no_ack", no_ack_out, 0);
      chk("t7_flush_tx_valid", tx_valid_out, 0);
      chk("t7_flush_tx_data_held", tx_data_out, 2);
      tick();
      chk("t7_flush_push_discarded", count_out, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
